tx_rx_link_fifo: RTL and testbench

- Elastic buffer between the TX stage (tx_vld/tx_data producer) and the RX stage (rx_ready consumer, writes words into its RAM).
- Decouples producer and consumer with a small synchronous FIFO and exposes occupancy.
- Counts delivered words and pulses frame_done after every FRAME_WORDS words handed to RX.
- RX uses frame_done as its end-of-frame qualifier ahead of rx_finish.

---
 rtl/tx_rx_link_fifo.sv | 143 ++++++++++++++
 tb/tb_tx_rx_link_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tx_rx_link_fifo.sv
// rtl/tx_rx_link_fifo.sv - TX->RX elastic FIFO with occupancy and frame_done pulse; optional stats via TX_RX_LINK_STATS_EN
module tx_rx_link_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int FRAME_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     tx_vld,
    input  logic [DATA_W-1:0]        tx_data,
    output logic                     tx_rdy,
    output logic                     rx_vld,
    output logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     frame_done
`ifdef TX_RX_LINK_STATS_EN
    ,
    output logic [15:0]              word_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  cnt_q;
    state_t            state_q;
    logic              frame_done_q;
    logic              push, pop;

    assign full       = (level_q == LVL_W'(DEPTH));
    assign empty      = (level_q == '0);
    assign tx_rdy     = !full && !clr;
    assign rx_vld     = !empty && !clr;
    assign rx_data    = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign frame_done = frame_done_q;
    assign push       = tx_vld && tx_rdy;
    assign pop        = rx_vld && rx_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    // A pop in DONE starts the next frame, so IDLE and DONE share the same entry logic.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (pop) begin
                        if (FRAME_WORDS == 1) begin
                            state_q      <= DONE;
                            cnt_q        <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_W'(1);
                        end
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (pop) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q      <= DONE;
                            cnt_q        <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef TX_RX_LINK_STATS_EN
    logic [15:0] word_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop && (word_cnt_q != 16'hFFFF))
                word_cnt_q <= word_cnt_q + 16'd1;
            if (rx_vld && !rx_ready && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tx_rx_link_fifo.sv
// tb/tb_tx_rx_link_fifo.sv - self-checking bench for tx_rx_link_fifo
module tb_tx_rx_link_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int FW     = 4;

    logic              clk = 1'b0;
    logic              clr;
    logic              tx_vld;
    logic [DATA_W-1:0] tx_data;
    logic              tx_rdy;
    logic              rx_vld;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    logic [$clog2(DEPTH):0] level;
    logic              full;
    logic              empty;
    logic              frame_done;
`ifdef TX_RX_LINK_STATS_EN
    logic [15:0]       word_cnt;
    logic [15:0]       stall_cnt;
`endif

    tx_rx_link_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FRAME_WORDS(FW)) dut (
        .clk        (clk),
        .clr        (clr),
        .tx_vld     (tx_vld),
        .tx_data    (tx_data),
        .tx_rdy     (tx_rdy),
        .rx_vld     (rx_vld),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .frame_done (frame_done)
`ifdef TX_RX_LINK_STATS_EN
        ,
        .word_cnt   (word_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int fd_seen = 0;
    int fd_base;
    int mcnt = 0;
    bit mfd = 1'b0;
    bit last_push;
    int mword = 0;
    int mstall = 0;
    logic [DATA_W-1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model at negedge, then advance the model past posedge.
    task automatic cycle();
        bit exp_rdy, exp_vld, do_push, do_pop;
        int lvl;
        @(negedge clk);
        lvl     = sb.size();
        exp_rdy = !clr && (lvl != DEPTH);
        exp_vld = !clr && (lvl != 0);
        chk("tx_rdy", 32'(tx_rdy), 32'(exp_rdy));
        chk("rx_vld", 32'(rx_vld), 32'(exp_vld));
        chk("level", 32'(level), 32'(lvl));
        chk("full", 32'(full), 32'(lvl == DEPTH));
        chk("empty", 32'(empty), 32'(lvl == 0));
        chk("frame_done", 32'(frame_done), 32'(mfd));
`ifdef TX_RX_LINK_STATS_EN
        chk("word_cnt", 32'(word_cnt), 32'(mword));
        chk("stall_cnt", 32'(stall_cnt), 32'(mstall));
`endif
        if (frame_done === 1'b1) fd_seen++;
        do_push = tx_vld && exp_rdy;
        do_pop  = rx_ready && exp_vld;
        if (do_pop) chk("rx_data", 32'(rx_data), 32'(sb.pop_front()));
        if (do_push) sb.push_back(tx_data);
        last_push = do_push;
        @(posedge clk);
        if (clr) begin
            sb.delete();
            mcnt = 0; mfd = 1'b0; mword = 0; mstall = 0;
        end else begin
            mfd = do_pop && (mcnt == FW - 1);
            if (do_pop) mcnt = (mcnt == FW - 1) ? 0 : mcnt + 1;
            if (do_pop && mword != 16'hFFFF) mword++;
            if (exp_vld && !rx_ready && mstall != 16'hFFFF) mstall++;
        end
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        tx_vld  = 1'b1;
        tx_data = d;
        last_push = 1'b0;
        for (int i = 0; i < 20 && !last_push; i++) cycle();
        chk("send_accepted", 32'(last_push), 32'd1);
        tx_vld = 1'b0;
    endtask

    task automatic drain();
        tx_vld   = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
        chk("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        clr = 1'b1; tx_vld = 1'b0; tx_data = '0; rx_ready = 1'b0;
        @(posedge clk); #1;
        cycle();
        clr = 1'b0;
        cycle();

        // single word with rx_ready high
        rx_ready = 1'b1;
        send(8'hA5);
        cycle();
        cycle();

        // fill to full, fifth word held until space frees up
        rx_ready = 1'b0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("full_after_fill", 32'(full), 32'd1);
        tx_vld = 1'b1; tx_data = 8'h55;
        repeat (3) cycle();
        chk("held_not_accepted", 32'(last_push), 32'd0);
        rx_ready = 1'b1;
        send(8'h55);
        drain();

        // simultaneous push/pop at level 2, pointers wrap
        rx_ready = 1'b0;
        send(8'h71); send(8'h72);
        rx_ready = 1'b1;
        send(8'h73); send(8'h74); send(8'h75);
        chk("level_steady", 32'(level), 32'd2);
        drain();

        // two frames
        clr = 1'b1; cycle(); clr = 1'b0;
        fd_base = fd_seen;
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h60 + 8'(i));
        drain();
        repeat (2) cycle();
        chk("two_frames", 32'(fd_seen - fd_base), 32'd2);

        // reset mid-frame
        fd_base = fd_seen;
        rx_ready = 1'b0;
        send(8'h81); send(8'h82); send(8'h83);
        rx_ready = 1'b1;
        repeat (2) cycle();
        rx_ready = 1'b0;
        clr = 1'b1; cycle(); clr = 1'b0;
        cycle();
        chk("midreset_level", 32'(level), 32'd0);
        chk("midreset_rx_vld", 32'(rx_vld), 32'd0);
        chk("midreset_no_frame", 32'(fd_seen - fd_base), 32'd0);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h90 + 8'(i));
        drain();
        repeat (2) cycle();
        chk("frame_after_reset", 32'(fd_seen - fd_base), 32'd1);

`ifdef TX_RX_LINK_STATS_EN
        clr = 1'b1; cycle(); clr = 1'b0;
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i));
        rx_ready = 1'b1;
        send(8'hB4); send(8'hB5);
        drain();
        chk("stats_words", 32'(word_cnt), 32'd6);
        chk("stats_stalls", 32'(stall_cnt), 32'd3);
        clr = 1'b1; cycle(); clr = 1'b0;
        cycle();
        chk("stats_words_clr", 32'(word_cnt), 32'd0);
        chk("stats_stalls_clr", 32'(stall_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
